adder_tree_2stage_arbiter: RTL and testbench



---
 rtl/adder_tree_2stage_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_adder_tree_2stage_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_tree_2stage_arbiter.sv
// rtl/adder_tree_2stage_arbiter.sv - round-robin arbiter sharing one pipelined 4-input adder tree
//
// Purpose: grants one of NREQ requesters per cycle onto an external adder tree
//   with TREE_LAT cycles of latency. Each issued operation is tagged with its
//   requester id and the sum is captured into a result FIFO. Issue is gated by
//   a credit check so the non-stallable tree can never overrun the FIFO.
// Optional: define ADDER_TREE_ARB_STATS_EN to add issue_count / stall_count.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid / req_ready      per-requester handshake (req_ready one-hot or zero)
//   req_data                   requester i operands at [16i+15:16i], nibbles op00..op11 LSB first
//   tree_inp00..tree_inp11     operands driven to the tree in the accept cycle
//   tree_sum                   tree output, valid TREE_LAT cycles after its operands
//   res_valid/res_ready        result FIFO head handshake
//   res_sum, res_id            head entry: sum and issuing requester
//   issue_count, stall_count   (optional) saturating accept / credit-stall counters
module adder_tree_2stage_arbiter #(
  parameter int NREQ       = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int TREE_LAT   = 2,
  parameter int IDW        = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*16-1:0]   req_data,
  output logic [3:0]           tree_inp00,
  output logic [3:0]           tree_inp01,
  output logic [3:0]           tree_inp10,
  output logic [3:0]           tree_inp11,
  input  logic [7:0]           tree_sum,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [7:0]           res_sum,
  output logic [IDW-1:0]       res_id
`ifdef ADDER_TREE_ARB_STATS_EN
  ,
  output logic [15:0]          issue_count,
  output logic [15:0]          stall_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [TREE_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [IDW-1:0]      tag_id_q [TREE_LAT];
  logic [IDW-1:0]      tag_id_d [TREE_LAT];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [7:0]          mem_sum_q [FIFO_DEPTH];
  logic [7:0]          mem_sum_d [FIFO_DEPTH];
  logic [IDW-1:0]      mem_id_q [FIFO_DEPTH];
  logic [IDW-1:0]      mem_id_d [FIFO_DEPTH];

  int                  inflight;
  int                  idx;
  logic                can_issue;
  logic                grant_vld;
  logic [IDW-1:0]      grant_idx;
  logic [15:0]         ops;
  logic                push, pop;

  // Arbitration and credit check. Every tagged op already in the tree holds a
  // FIFO slot; pops this cycle are deliberately not credited.
  always_comb begin
    inflight  = 0;
    idx       = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < TREE_LAT; k++) begin
      inflight = inflight + int'(tag_vld_q[k]);
    end
    can_issue = (int'(count_q) + inflight) < FIFO_DEPTH;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!grant_vld && req_valid[idx]) begin
        grant_vld = 1'b1;
        grant_idx = IDW'(idx);
      end
    end
    if (!can_issue || reset) grant_vld = 1'b0;
    req_ready  = grant_vld ? (NREQ'(1) << grant_idx) : '0;
    ops        = grant_vld ? req_data[16*int'(grant_idx) +: 16] : 16'h0;
    tree_inp00 = ops[3:0];
    tree_inp01 = ops[7:4];
    tree_inp10 = ops[11:8];
    tree_inp11 = ops[15:12];
  end

  // grant_vld implies the granted requester's valid is high, so it is the accept.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_vld) begin
      rr_ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end
    tag_vld_d    = tag_vld_q;
    tag_id_d     = tag_id_q;
    tag_vld_d[0] = grant_vld;
    tag_id_d[0]  = grant_idx;
    for (int k = 1; k < TREE_LAT; k++) begin
      tag_vld_d[k] = tag_vld_q[k-1];
      tag_id_d[k]  = tag_id_q[k-1];
    end
  end

  // Result FIFO: the last tag stage lines up with tree_sum for the same op.
  assign push      = tag_vld_q[TREE_LAT-1];
  assign res_valid = (count_q != '0);
  assign pop       = res_valid & res_ready;
  assign res_sum   = mem_sum_q[rd_ptr_q];
  assign res_id    = mem_id_q[rd_ptr_q];

  always_comb begin
    mem_sum_d = mem_sum_q;
    mem_id_d  = mem_id_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (push) begin
      mem_sum_d[wr_ptr_q] = tree_sum;
      mem_id_d[wr_ptr_q]  = tag_id_q[TREE_LAT-1];
      wr_ptr_d            = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q  <= '0;
      tag_vld_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      for (int k = 0; k < TREE_LAT; k++) tag_id_q[k] <= '0;
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        mem_sum_q[k] <= '0;
        mem_id_q[k]  <= '0;
      end
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      tag_vld_q <= tag_vld_d;
      tag_id_q  <= tag_id_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      mem_sum_q <= mem_sum_d;
      mem_id_q  <= mem_id_d;
    end
  end

`ifdef ADDER_TREE_ARB_STATS_EN
  logic [15:0] issue_cnt_q, issue_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    issue_cnt_d = issue_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (grant_vld && issue_cnt_q != 16'hFFFF) issue_cnt_d = issue_cnt_q + 16'd1;
    if ((|req_valid) && !can_issue && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign issue_count = issue_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_adder_tree_2stage_arbiter.sv
// tb/tb_adder_tree_2stage_arbiter.sv - self-checking bench for adder_tree_2stage_arbiter
module tb_adder_tree_2stage_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_data;
  logic [3:0]  tree_inp00, tree_inp01, tree_inp10, tree_inp11;
  logic [7:0]  tree_sum;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_sum;
  logic [1:0]  res_id;
`ifdef ADDER_TREE_ARB_STATS_EN
  logic [15:0] issue_count, stall_count;
`endif

  int n_vec = 0;
  int n_bad = 0;

  adder_tree_2stage_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .tree_inp00 (tree_inp00),
    .tree_inp01 (tree_inp01),
    .tree_inp10 (tree_inp10),
    .tree_inp11 (tree_inp11),
    .tree_sum   (tree_sum),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_sum    (res_sum),
    .res_id     (res_id)
`ifdef ADDER_TREE_ARB_STATS_EN
    ,
    .issue_count(issue_count),
    .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  // External 2-stage tree model: pair sums, then total; no reset.
  logic [4:0] s1a, s1b;
  logic [7:0] s2;
  always @(posedge clk) begin
    s1a <= {1'b0, tree_inp00} + {1'b0, tree_inp01};
    s1b <= {1'b0, tree_inp10} + {1'b0, tree_inp11};
    s2  <= {3'b0, s1a} + {3'b0, s1b};
  end
  assign tree_sum = s2;

  // FIFO occupancy must never exceed its depth.
  always @(negedge clk) begin
    if (!reset && dut.count_q > 3'd4) begin
      $display("FAIL fifo_overflow: count %0d exceeds depth 4", dut.count_q);
      n_bad++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
      n_bad++;
    end
  endtask

  typedef struct {
    int          req;
    logic [15:0] ops;
    logic [7:0]  sum;
  } vec_t;

  vec_t vecs[5];

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    req_valid = 4'hF;
    res_ready = 1'b0;
    req_data  = '0;
    repeat (2) @(negedge clk);
    #1 chk("reset_req_ready", req_ready, 0);
    @(negedge clk);
    reset     = 1'b0;
    req_valid = 4'h0;
    #1;
    chk("reset_res_valid", res_valid, 0);
    chk("reset_res_sum_id", {res_sum, res_id}, 0);
  endtask

  // Single request: accept this cycle, expect result visible exactly 3 cycles later.
  task automatic run_vec(input vec_t v);
    int lat;
    bit got;
    @(negedge clk);
    req_data               = '0;
    req_data[16*v.req +: 16] = v.ops;
    req_valid              = 4'(1 << v.req);
    res_ready              = 1'b1;
    #1;
    chk("vec_accept", req_ready, 1 << v.req);
    chk("vec_tree_ops", {tree_inp11, tree_inp10, tree_inp01, tree_inp00}, v.ops);
    lat = 0;
    got = 0;
    for (int c = 1; c <= 8 && !got; c++) begin
      @(negedge clk);
      req_valid = 4'h0;
      req_data  = '0;
      #1;
      if (c == 1) chk("idle_tree_zero", {tree_inp11, tree_inp10, tree_inp01, tree_inp00}, 0);
      if (res_valid) begin
        got = 1;
        lat = c;
        chk("vec_sum", res_sum, v.sum);
        chk("vec_id", res_id, v.req);
      end
    end
    chk("vec_latency", lat, 3);
  endtask

  initial begin
    int acc;
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    res_ready = 1'b0;

    vecs[0] = '{req: 2, ops: 16'h6543, sum: 8'd18};
    vecs[1] = '{req: 0, ops: 16'hFFFF, sum: 8'd60};
    vecs[2] = '{req: 3, ops: 16'h0000, sum: 8'd0};
    vecs[3] = '{req: 1, ops: 16'h4321, sum: 8'd10};
    vecs[4] = '{req: 2, ops: 16'h0F0F, sum: 8'd30};

    do_reset();
    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Round robin, all requesters streaming, one result per cycle.
    do_reset();
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) req_data[16*i +: 16] = {4{4'(i + 1)}};
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      req_valid = (c < 8) ? 4'hF : 4'h0;
      #1;
      if (c < 8) chk("rr_grant", req_ready, 1 << (c % 4));
      if (c >= 3) begin
        chk("rr_valid", res_valid, 1);
        chk("rr_id", res_id, (c - 3) % 4);
        chk("rr_sum", res_sum, 4 * ((c - 3) % 4 + 1));
      end
    end
    @(negedge clk);
    req_valid = 4'h0;
    #1 chk("rr_drained", res_valid, 0);

    // Backpressure: exactly FIFO_DEPTH accepts, then drain and resume.
    do_reset();
    res_ready       = 1'b0;
    req_data[15:0]  = 16'hFFFF;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      req_valid = 4'b0001;
      #1;
      if (req_ready[0]) acc++;
    end
    chk("bp_accepts", acc, 4);
    chk("bp_ready_low", req_ready, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      req_valid = (c < 2) ? 4'b0001 : 4'b0000;
      res_ready = 1'b1;
      #1;
      if (c == 0) chk("bp_pop_no_credit", req_ready, 0);
      if (c == 1) chk("bp_resume", req_ready, 1);
      chk("bp_res_valid", res_valid, 1);
      chk("bp_res_sum", res_sum, 60);
    end
    @(negedge clk);
    #1 chk("bp_empty", res_valid, 0);

    // Reset one cycle after two accepts discards everything in flight.
    do_reset();
    res_ready = 1'b1;
    @(negedge clk);
    req_data  = 64'h0000_0000_2222_1111;
    req_valid = 4'b0010;
    #1 chk("rst_acc1", req_ready, 4'b0010);
    @(negedge clk);
    req_data  = 64'h0000_2222_1111_0000;
    req_valid = 4'b0100;
    #1 chk("rst_acc2", req_ready, 4'b0100);
    @(negedge clk);
    req_valid = 4'b0000;
    reset     = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (res_valid) acc++;
      @(negedge clk);
    end
    chk("rst_no_results", acc, 0);
    run_vec(vecs[0]);

`ifdef ADDER_TREE_ARB_STATS_EN
    do_reset();
    res_ready      = 1'b0;
    req_data[15:0] = 16'h1234;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      req_valid = 4'b0001;
    end
    @(negedge clk);
    req_valid = 4'b0000;
    res_ready = 1'b1;
    repeat (8) @(negedge clk);
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = 4'b0000;
    repeat (4) @(negedge clk);
    #1;
    chk("stats_issue", issue_count, 6);
    chk("stats_stall", stall_count, 3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
